har_feature_loader: RTL and testbench

HAR_FEATURE_LOADER -- requirements
Module: har_feature_loader

---
 rtl/har_pkg.sv | 21 ++
 rtl/har_feature_loader.sv | 116 +++++++++++
 tb/tb_har_feature_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/har_pkg.sv
// Shared constants, output-state encoding and feature saturation for the HAR
// classifier front end.
package har_pkg;

   localparam int IMG_SIZE    = 95;
   localparam int M           = 15;
   localparam int NUM_CLASSES = 6;

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      HOLD
   } out_state_e;

   function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int clip);
      if (x > clip)       return clip;
      else if (x < -clip) return -clip;
      else                return x;
   endfunction

endpackage

// File: rtl/har_feature_loader.sv
// Collects a window of saturated features into a shadow buffer, then copies it
// to a frozen image and pulses V_valid, holding the image for HOLD_CYCLES.
module har_feature_loader #(
   parameter int IMG_SIZE    = har_pkg::IMG_SIZE,
   parameter int M           = har_pkg::M,
   parameter int HOLD_CYCLES = 4,
   parameter int CLIP        = 20000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic signed [M:0]          s_data,
   input  logic                       s_last,
   output logic [IMG_SIZE-1:0][M:0]   image,
   output logic                       V_valid,
   output logic                       frame_err,
   output logic [15:0]                frame_count
);
   import har_pkg::*;

   localparam int IW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

   logic [IMG_SIZE-1:0][M:0] shadow;
   logic [IW-1:0]            idx;
   logic                     full;
   logic                     discard;
   out_state_e               state;
   logic [7:0]               holdcnt;

   logic                     xfer;
   logic                     at_end;
   logic signed [31:0]       sat_wide;
   logic [M:0]               sat_data;

   assign s_ready  = !full || discard;
   assign xfer     = s_valid && s_ready;
   assign at_end   = (idx == IW'(IMG_SIZE-1));
   assign sat_wide = sat(32'(s_data), CLIP);
   assign sat_data = sat_wide[M:0];

   // Shadow contents are don't-care until full is set, so no reset needed.
   always_ff @(posedge clk) begin
      if (xfer && !discard) shadow[idx] <= sat_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx       <= '0;
         full      <= 1'b0;
         discard   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (state == IDLE && full) full <= 1'b0;
         if (xfer) begin
            if (discard) begin
               if (s_last) begin
                  discard <= 1'b0;
                  idx     <= '0;
               end
            end else if (at_end) begin
               idx <= '0;
               if (s_last) full <= 1'b1;
               else begin
                  frame_err <= 1'b1;
                  discard   <= 1'b1;
               end
            end else if (s_last) begin
               frame_err <= 1'b1;
               idx       <= '0;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   // frame_count advances with the copy so it already reads +1 while V_valid is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         image       <= '0;
         V_valid     <= 1'b0;
         frame_count <= '0;
         holdcnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               V_valid <= 1'b0;
               if (full) begin
                  image       <= shadow;
                  V_valid     <= 1'b1;
                  frame_count <= frame_count + 1'b1;
                  state       <= FIRE;
               end
            end
            FIRE: begin
               V_valid <= 1'b0;
               holdcnt <= 8'(HOLD_CYCLES-1);
               state   <= HOLD;
            end
            HOLD: begin
               V_valid <= 1'b0;
               if (holdcnt == 8'd0) state <= IDLE;
               else                 holdcnt <= holdcnt - 1'b1;
            end
            default: begin
               V_valid <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_har_feature_loader.sv
// Bench for har_feature_loader: two instances (full-size window and a 4-feature
// window for tight back-to-back timing) checked every cycle against a frame-level model.
module tb_har_feature_loader;

   localparam int HOLD = 4;
   localparam int CLIP = 20000;
   localparam int SZ0  = 95;
   localparam int SZ1  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sv[2], sl[2], rdy[2], vv[2], ferr[2];
   logic signed [15:0] sd[2];
   logic [15:0] fcnt[2];
   logic [SZ0-1:0][15:0] img0;
   logic [SZ1-1:0][15:0] img1;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   har_feature_loader #(.IMG_SIZE(SZ0), .M(15), .HOLD_CYCLES(HOLD), .CLIP(CLIP)) u0 (
      .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(rdy[0]), .s_data(sd[0]),
      .s_last(sl[0]), .image(img0), .V_valid(vv[0]), .frame_err(ferr[0]),
      .frame_count(fcnt[0]));

   har_feature_loader #(.IMG_SIZE(SZ1), .M(15), .HOLD_CYCLES(HOLD), .CLIP(CLIP)) u1 (
      .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(rdy[1]), .s_data(sd[1]),
      .s_last(sl[1]), .image(img1), .V_valid(vv[1]), .frame_err(ferr[1]),
      .frame_count(fcnt[1]));

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int isz(input int d);
      return d ? SZ1 : SZ0;
   endfunction

   function automatic int clip_val(input int x);
      return (x > CLIP) ? CLIP : (x < -CLIP) ? -CLIP : x;
   endfunction

   function automatic int dut_img(input int d, input int i);
      if (d == 0) return $signed(img0[i]);
      return $signed(img1[i]);
   endfunction

   // Frame-level model: a completed frame waits as "pending"; it is copied on the
   // first edge after completion that is also >= HOLD+2 edges past the previous copy.
   int  ecnt = 0;
   int  m_cnt[2], m_pc[2], m_prev[2];
   bit  m_drop[2], m_pend[2], m_has[2];
   int  m_buf[2][SZ0], m_pimg[2][SZ0], e_img[2][SZ0];
   bit  e_v[2], e_err[2], e_rdy[2];
   int  e_cnt[2];

   always @(posedge clk) begin
      ecnt++;
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            m_cnt[d] = 0; m_drop[d] = 0; m_pend[d] = 0; m_has[d] = 0;
            e_v[d] = 0; e_err[d] = 0; e_cnt[d] = 0; e_rdy[d] = 1;
            for (int i = 0; i < SZ0; i++) e_img[d][i] = 0;
         end else begin
            e_v[d] = 0; e_err[d] = 0;
            if (m_pend[d] && ecnt > m_pc[d] && (!m_has[d] || ecnt >= m_prev[d] + HOLD + 2)) begin
               e_img[d] = m_pimg[d];
               m_pend[d] = 0; m_has[d] = 1; m_prev[d] = ecnt;
               e_v[d] = 1;
               e_cnt[d] = (e_cnt[d] + 1) % 65536;
            end
            if (sv[d] && e_rdy[d]) begin
               if (m_drop[d]) begin
                  if (sl[d]) m_drop[d] = 0;
               end else begin
                  m_buf[d][m_cnt[d]] = clip_val(int'(sd[d]));
                  if (m_cnt[d] == isz(d) - 1) begin
                     m_cnt[d] = 0;
                     if (sl[d]) begin
                        m_pend[d] = 1; m_pc[d] = ecnt; m_pimg[d] = m_buf[d];
                     end else begin
                        e_err[d] = 1; m_drop[d] = 1;
                     end
                  end else if (sl[d]) begin
                     e_err[d] = 1; m_cnt[d] = 0;
                  end else begin
                     m_cnt[d]++;
                  end
               end
            end
            e_rdy[d] = !m_pend[d];
         end
      end
   end

   int v_seen[2], err_seen[2];
   longint vlast[2], vprev[2], tlast[2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int bad;
         chk($sformatf("s_ready%0d", d), rdy[d], e_rdy[d]);
         chk($sformatf("V_valid%0d", d), vv[d], e_v[d]);
         chk($sformatf("frame_err%0d", d), ferr[d], e_err[d]);
         chk($sformatf("frame_count%0d", d), fcnt[d], e_cnt[d]);
         bad = -1;
         for (int i = 0; i < isz(d); i++)
            if (dut_img(d, i) != e_img[d][i]) bad = i;
         chk($sformatf("image%0d_bad_index", d), bad, -1);
         if (vv[d] === 1'b1) begin
            v_seen[d]++;
            vprev[d] = vlast[d];
            vlast[d] = $time + 5;
         end
         if (ferr[d] === 1'b1) err_seen[d]++;
      end
   end

   task automatic send(input int d, input int val, input bit last, input int gap);
      int n = 0;
      repeat (gap) @(negedge clk);
      sv[d] = 1'b1; sd[d] = 16'(val); sl[d] = last;
      while (rdy[d] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("send_ready_timeout", 0, 1);
      @(posedge clk);
      tlast[d] = $time;
      @(negedge clk);
      sv[d] = 1'b0; sl[d] = 1'b0;
   endtask

   // mode 0: value = position, 1: random, 2: saturation probes then position
   task automatic frame(input int d, input int n, input int mode, input int maxgap);
      for (int i = 0; i < n; i++) begin
         int v;
         if (mode == 1)                v = int'($signed(16'($urandom)));
         else if (mode == 2 && i == 0) v = 30000;
         else if (mode == 2 && i == 1) v = -32768;
         else if (mode == 2 && i == 2) v = 1234;
         else                          v = i;
         send(d, v, (i == n - 1), (maxgap > 0) ? int'($urandom_range(maxgap)) : 0);
      end
   endtask

   task automatic wait_v(input int d, input int target, input int budget);
      int n = 0;
      while (v_seen[d] < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_V_valid", (v_seen[d] >= target), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int vb, eb;
      for (int d = 0; d < 2; d++) begin
         sv[d] = 0; sl[d] = 0; sd[d] = '0;
         v_seen[d] = 0; err_seen[d] = 0; vlast[d] = 0; vprev[d] = 0; tlast[d] = 0;
      end
      repeat (3) @(negedge clk);
      chk("reset_frame_count", fcnt[0], 0);
      chk("reset_s_ready", rdy[0], 1);
      chk("reset_image_last", dut_img(0, 94), 0);
      #2 rst = 1'b1;
      @(negedge clk);

      // single clean window, value = index
      vb = v_seen[0];
      frame(0, SZ0, 0, 0);
      wait_v(0, vb + 1, 20);
      chk("latency_cycles", (vlast[0] - tlast[0]) / 10, 2);
      chk("img_k0", dut_img(0, 0), 0);
      chk("img_k50", dut_img(0, 50), 50);
      chk("img_k94", dut_img(0, 94), 94);
      chk("frame_count_first", fcnt[0], 1);

      // saturation
      repeat (8) @(negedge clk);
      vb = v_seen[0];
      frame(0, SZ0, 2, 0);
      wait_v(0, vb + 1, 20);
      chk("sat_pos", dut_img(0, 0), 20000);
      chk("sat_neg", dut_img(0, 1), -20000);
      chk("sat_pass", dut_img(0, 2), 1234);

      // early s_last on feature 50
      repeat (8) @(negedge clk);
      vb = v_seen[0]; eb = err_seen[0];
      frame(0, 50, 0, 0);
      repeat (10) @(negedge clk);
      chk("early_last_err", err_seen[0], eb + 1);
      chk("early_last_no_v", v_seen[0], vb);
      frame(0, SZ0, 1, 1);
      wait_v(0, vb + 1, 20);

      // overlong window: 96 features, s_last on the 96th
      repeat (8) @(negedge clk);
      vb = v_seen[0]; eb = err_seen[0];
      frame(0, SZ0 + 1, 0, 0);
      repeat (10) @(negedge clk);
      chk("long_frame_err", err_seen[0], eb + 1);
      chk("long_frame_no_v", v_seen[0], vb);
      frame(0, SZ0, 0, 0);
      wait_v(0, vb + 1, 20);
      chk("after_long_img94", dut_img(0, 94), 94);

      // back-to-back windows on the small instance
      vb = v_seen[1];
      frame(1, SZ1, 0, 0);
      frame(1, SZ1, 1, 0);
      wait_v(1, vb + 2, 40);
      chk("b2b_spacing_cycles", (vlast[1] - vprev[1]) / 10, HOLD + 2);

      // randomized windows, lengths around the boundary
      for (int r = 0; r < 40; r++) begin
         int d, n, pick;
         d = int'($urandom_range(1));
         pick = int'($urandom_range(9));
         if (pick < 6)      n = isz(d);
         else if (pick < 8) n = int'($urandom_range(isz(d) - 1, 1));
         else               n = isz(d) + int'($urandom_range(3, 1));
         frame(d, n, 1, 2);
         repeat (int'($urandom_range(8))) @(negedge clk);
      end
      repeat (20) @(negedge clk);

      // reset with a partial window loaded
      vb = v_seen[0];
      frame(0, SZ0, 0, 0);
      wait_v(0, vb + 1, 20);
      for (int i = 0; i < 40; i++) send(0, 100 + i, 1'b0, 0);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_frame_count", fcnt[0], 0);
      chk("rst_img94", dut_img(0, 94), 0);
      chk("rst_V_valid", vv[0], 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      vb = v_seen[0];
      repeat (12) @(negedge clk);
      chk("rst_no_v_on_release", v_seen[0], vb);
      frame(0, SZ0, 0, 0);
      wait_v(0, vb + 1, 20);
      chk("rst_fresh_count", fcnt[0], 1);
      repeat (10) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
